// File: rtl/draw_duck_pkg.sv
// rtl/draw_duck_pkg.sv - shared duck sprite geometry and VGA bus bundle type
package draw_duck_pkg;

   localparam int SPRITE_W       = 96;
   localparam int SPRITE_H       = 60;
   localparam int DUCK_ROM_DEPTH = SPRITE_W * SPRITE_H;
   localparam int ADDR_W         = $clog2(DUCK_ROM_DEPTH);

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        hblnk;
      logic        vsync;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_bus_t;

endpackage

// File: rtl/draw_duck_if.sv
// rtl/draw_duck_if.sv - VGA pixel-chain bus between render stages
interface draw_duck_if;

   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        hblnk;
   logic        vsync;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);

endinterface

// File: rtl/draw_duck_signal_delay.sv
// rtl/draw_duck_signal_delay.sv - fixed-depth register delay line with sync reset
module draw_duck_signal_delay #(
   parameter int WIDTH   = 1,
   parameter int CLK_DEL = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] delayed
);

   logic [WIDTH-1:0] stage [CLK_DEL];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CLK_DEL; i++) stage[i] <= '0;
      end else begin
         stage[0] <= data;
         for (int i = 1; i < CLK_DEL; i++) stage[i] <= stage[i-1];
      end
   end

   assign delayed = stage[CLK_DEL-1];

endmodule

// File: rtl/draw_duck.sv
// rtl/draw_duck.sv - duck sprite overlay: ROM address generation and compositing
module draw_duck
   import draw_duck_pkg::*;
#(
   parameter logic [11:0] TRANSP_RGB = 12'h000
) (
   input  logic              clk,
   input  logic              rst_n,
   draw_duck_if.slave        upstream,
   draw_duck_if.master       downstream,
   input  logic [10:0]       xpos,
   input  logic [10:0]       ypos,
   input  logic              enable,
   input  logic              flip_h,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_rgb
);

   localparam logic [11:0] W12 = 12'(SPRITE_W);
   localparam logic [11:0] H12 = 12'(SPRITE_H);

   logic [10:0] xl, yl;
   logic        en_l, flip_l, vblnk_prev;
   logic [11:0] hc, vc, x12, y12, rx, ry, cx;
   logic [12:0] ry13, addr;
   logic        in_box, in_box_d1, in_box_d2, draw;
   vga_bus_t    bus_in, bus_d2;

   // 12-bit bounds keep a sprite near the right/bottom edge from wrapping to 0
   assign hc     = {1'b0, upstream.hcount};
   assign vc     = {1'b0, upstream.vcount};
   assign x12    = {1'b0, xl};
   assign y12    = {1'b0, yl};
   assign rx     = hc - x12;
   assign ry     = vc - y12;
   assign in_box = en_l && (hc >= x12) && (hc < x12 + W12)
                        && (vc >= y12) && (vc < y12 + H12);
   assign cx     = flip_l ? (W12 - 12'd1 - rx) : rx;
   assign ry13   = {1'b0, ry};
   assign addr   = (ry13 << 6) + (ry13 << 5) + {1'b0, cx};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xl         <= '0;
         yl         <= '0;
         en_l       <= 1'b0;
         flip_l     <= 1'b0;
         vblnk_prev <= 1'b0;
         rom_addr   <= '0;
         in_box_d1  <= 1'b0;
         in_box_d2  <= 1'b0;
      end else begin
         vblnk_prev <= upstream.vblnk;
         if (upstream.vblnk && !vblnk_prev) begin
            xl     <= xpos;
            yl     <= ypos;
            en_l   <= enable;
            flip_l <= flip_h;
         end
         rom_addr  <= in_box ? addr : '0;
         in_box_d1 <= in_box;
         in_box_d2 <= in_box_d1;
      end
   end

   // Two stages here plus the output register below give the 3-clk chain latency
   assign bus_in = {upstream.hcount, upstream.vcount, upstream.hsync, upstream.hblnk,
                    upstream.vsync, upstream.vblnk, upstream.rgb};

   draw_duck_signal_delay #(
      .WIDTH   ($bits(vga_bus_t)),
      .CLK_DEL (2)
   ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .data    (bus_in),
      .delayed (bus_d2)
   );

   assign draw = in_box_d2 && !bus_d2.hblnk && !bus_d2.vblnk && (rom_rgb != TRANSP_RGB);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         downstream.hcount <= '0;
         downstream.vcount <= '0;
         downstream.hsync  <= 1'b0;
         downstream.hblnk  <= 1'b0;
         downstream.vsync  <= 1'b0;
         downstream.vblnk  <= 1'b0;
         downstream.rgb    <= '0;
      end else begin
         downstream.hcount <= bus_d2.hcount;
         downstream.vcount <= bus_d2.vcount;
         downstream.hsync  <= bus_d2.hsync;
         downstream.hblnk  <= bus_d2.hblnk;
         downstream.vsync  <= bus_d2.vsync;
         downstream.vblnk  <= bus_d2.vblnk;
         downstream.rgb    <= draw ? rom_rgb : bus_d2.rgb;
      end
   end

endmodule

// File: tb/tb_draw_duck.sv
// tb/tb_draw_duck.sv - self-checking bench for draw_duck with ROM and frame-latch model
module tb_draw_duck;

   typedef struct {
      logic [10:0] h, v;
      logic        hs, hb, vs, vb;
      logic [11:0] rgb;
      logic [10:0] x, y;
      logic        en, fl;
   } in_t;

   typedef struct {
      logic [10:0] h, v;
      logic        hs, hb, vs, vb;
      logic [11:0] rgb;
   } out_t;

   typedef struct {
      logic fl;
      int   h, v;
      logic blank;
      int   addr;
      logic inbox;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] xpos, ypos;
   logic        enable, flip_h;
   logic [12:0] rom_addr;
   logic [11:0] rom_rgb;
   logic [11:0] rom [8192];

   draw_duck_if vin ();
   draw_duck_if vout ();

   draw_duck dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .upstream   (vin),
      .downstream (vout),
      .xpos       (xpos),
      .ypos       (ypos),
      .enable     (enable),
      .flip_h     (flip_h),
      .rom_addr   (rom_addr),
      .rom_rgb    (rom_rgb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_rgb <= rom[rom_addr];

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   in_t  cur;
   out_t q[$];
   out_t zero_o;
   int   m_x, m_y;
   logic m_en, m_fl, m_prev;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_out(input out_t e);
      chk("hcount_out", vout.hcount, e.h);
      chk("vcount_out", vout.vcount, e.v);
      chk("hsync_out",  vout.hsync,  e.hs);
      chk("hblnk_out",  vout.hblnk,  e.hb);
      chk("vsync_out",  vout.vsync,  e.vs);
      chk("vblnk_out",  vout.vblnk,  e.vb);
      chk("rgb_out",    vout.rgb,    e.rgb);
   endtask

   // One pixel clock; the reference model works on whole-pixel geometry, not pipeline stages
   task automatic step();
      out_t o;
      int   hh, vv, a;
      logic ib;
      vin.hcount = cur.h; vin.vcount = cur.v;
      vin.hsync  = cur.hs; vin.hblnk = cur.hb;
      vin.vsync  = cur.vs; vin.vblnk = cur.vb;
      vin.rgb    = cur.rgb;
      xpos = cur.x; ypos = cur.y; enable = cur.en; flip_h = cur.fl;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         m_x = 0; m_y = 0; m_en = 1'b0; m_fl = 1'b0; m_prev = 1'b0;
         q.delete();
         q.push_back(zero_o);
         q.push_back(zero_o);
         chk("rst_rom_addr", rom_addr, 0);
         chk_out(zero_o);
      end else begin
         hh = cur.h;
         vv = cur.v;
         ib = m_en && hh >= m_x && hh < m_x + 96 && vv >= m_y && vv < m_y + 60;
         a  = ib ? (vv - m_y) * 96 + (m_fl ? 95 - (hh - m_x) : hh - m_x) : 0;
         o.h = cur.h; o.v = cur.v; o.hs = cur.hs; o.hb = cur.hb; o.vs = cur.vs; o.vb = cur.vb;
         o.rgb = (ib && !cur.hb && !cur.vb && rom[a] != 12'h000) ? rom[a] : cur.rgb;
         if (cur.vb && !m_prev) begin
            m_x = cur.x; m_y = cur.y; m_en = cur.en; m_fl = cur.fl;
         end
         m_prev = cur.vb;
         chk("rom_addr", rom_addr, a);
         q.push_back(o);
         chk_out(q.pop_front());
      end
   endtask

   task automatic latch(input int x, input int y, input logic en, input logic fl);
      cur.vb = 1'b0; step();
      cur.x = 11'(x); cur.y = 11'(y); cur.en = en; cur.fl = fl;
      cur.vb = 1'b1; step();
      cur.vb = 1'b0; step();
   endtask

   vec_t        vecs[$];
   logic [11:0] saved_rgb;
   int          exp_rgb, hh, vv;
   logic        last_fl;

   initial begin
      zero_o = '{default: '0};
      for (int a = 0; a < 8192; a++)
         rom[a] = (a < 5760 && $urandom_range(0, 4) != 0) ? 12'($urandom) : 12'h000;
      rom[193] = 12'hABC; rom[286] = 12'h000; rom[95] = 12'h5A5; rom[0] = 12'h0F0;
      rom[5759] = 12'h123; rom[5664] = 12'h321; rom[983] = 12'h777; rom[1010] = 12'h888;

      vecs = '{
         '{0, 101, 202, 0, 193,  1},
         '{0, 100, 200, 0, 0,    1},
         '{0, 195, 259, 0, 5759, 1},
         '{0, 101, 202, 1, 193,  1},
         '{0, 196, 200, 0, 0,    0},
         '{0,  99, 200, 0, 0,    0},
         '{0, 100, 260, 0, 0,    0},
         '{0, 100, 199, 0, 0,    0},
         '{1, 100, 200, 0, 95,   1},
         '{1, 195, 200, 0, 0,    1},
         '{1, 101, 202, 0, 286,  1},
         '{1, 195, 259, 0, 5664, 1}
      };

      // Reset held with toggling inputs
      cur = '{default: '0};
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cur.h = 11'($urandom); cur.v = 11'($urandom); cur.rgb = 12'($urandom);
         cur.hs = 1'($urandom); cur.vb = 1'($urandom); cur.en = 1'b1;
         step();
      end
      rst_n = 1'b1;
      cur = '{default: '0};

      // Sprite disabled: pure passthrough
      latch(100, 200, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         cur.h = 11'($urandom_range(0, 1343)); cur.v = 11'($urandom_range(0, 805));
         cur.rgb = 12'($urandom); cur.hs = 1'($urandom); cur.vs = 1'($urandom);
         cur.hb = 1'($urandom);
         step();
      end
      cur = '{default: '0};

      // Table of address / compositing vectors
      last_fl = vecs[0].fl;
      latch(100, 200, 1'b1, last_fl);
      foreach (vecs[k]) begin
         if (vecs[k].fl != last_fl) begin
            last_fl = vecs[k].fl;
            latch(100, 200, 1'b1, last_fl);
         end
         cur.h = 11'(vecs[k].h); cur.v = 11'(vecs[k].v); cur.hb = vecs[k].blank;
         cur.rgb = 12'($urandom);
         saved_rgb = cur.rgb;
         step();
         chk("vec_rom_addr", rom_addr, vecs[k].addr);
         cur.h = 0; cur.v = 0; cur.hb = 1'b0;
         step();
         step();
         exp_rgb = (vecs[k].inbox && !vecs[k].blank && rom[vecs[k].addr] != 12'h000)
                   ? rom[vecs[k].addr] : saved_rgb;
         chk("vec_rgb_out", vout.rgb, exp_rgb);
         chk("vec_hcount_out", vout.hcount, vecs[k].h);
      end

      // Position change mid-frame waits for the next vblank rise
      latch(100, 200, 1'b1, 1'b0);
      cur.x = 11'd300; cur.h = 11'd150; cur.v = 11'd210;
      step();
      chk("latch_hold_addr", rom_addr, 1010);
      latch(300, 200, 1'b1, 1'b0);
      cur.h = 11'd150; cur.v = 11'd210;
      step();
      chk("latch_new_old_pos", rom_addr, 0);
      cur.h = 11'd310;
      step();
      chk("latch_new_addr", rom_addr, 970);

      // Right-edge clip with no wrap to column 0
      latch(1000, 200, 1'b1, 1'b0);
      cur.h = 11'd1023; cur.v = 11'd210;
      step();
      chk("clip_edge_addr", rom_addr, 983);
      for (int h = 0; h < 72; h++) begin
         cur.h = 11'(h);
         step();
         chk("nowrap_addr", rom_addr, 0);
      end

      // Mid-frame reset drops the latched enable
      latch(100, 200, 1'b1, 1'b0);
      cur.h = 11'd101; cur.v = 11'd202;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_addr", rom_addr, 0);
      step();
      step();
      chk("post_reset_rgb", vout.rgb, cur.rgb);

      // Randomised frames around the latched sprite, with positions changing every clock
      cur = '{default: '0};
      for (int i = 0; i < 3000; i++) begin
         if (cur.vb) cur.vb = 1'($urandom_range(0, 1));
         else        cur.vb = ($urandom_range(0, 59) == 0);
         cur.x  = 11'($urandom_range(0, 1023));
         cur.y  = 11'($urandom_range(0, 767));
         cur.en = ($urandom_range(0, 3) != 0);
         cur.fl = 1'($urandom);
         hh = m_x - 8 + int'($urandom_range(0, 112));
         vv = m_y - 4 + int'($urandom_range(0, 68));
         if (hh < 0) hh = 0;
         if (vv < 0) vv = 0;
         if (hh > 2047) hh = 2047;
         if (vv > 2047) vv = 2047;
         cur.h  = 11'(hh);
         cur.v  = 11'(vv);
         cur.hb = ($urandom_range(0, 7) == 0);
         cur.hs = 1'($urandom);
         cur.vs = 1'($urandom);
         cur.rgb = 12'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
